present_round_engine: RTL and testbench

PRESENT_ROUND_ENGINE -- requirements
Module: present_round_engine

---
 rtl/present_pkg.sv | 25 ++
 rtl/present_sbox_layer.sv | 18 +
 rtl/present_round_engine.sv | 142 ++++++++++++++
 tb/tb_present_round_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants, S-box table and FSM states for the PRESENT-80 engine
`ifndef PRESENT_SIZE
`define PRESENT_SIZE 64
`endif

package present_pkg;

    localparam int KEY_WIDTH  = 80;
    localparam int NUM_ROUNDS = 31;

    // Nibble k of the table (bits 4k+3..4k) holds S(k): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
    localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present_sbox_layer.sv
// rtl/present_sbox_layer.sv - PRESENT S-box applied to every nibble of the state in parallel
`ifndef PRESENT_SIZE
`define PRESENT_SIZE 64
`endif

module present_sbox_layer #(
    parameter int BLOCK_WIDTH = `PRESENT_SIZE
) (
    input  logic [BLOCK_WIDTH-1:0] i_data,
    output logic [BLOCK_WIDTH-1:0] o_data
);

    genvar g;
    for (g = 0; g < BLOCK_WIDTH / 4; g++) begin : g_nibble
        assign o_data[4*g +: 4] = present_pkg::sbox(i_data[4*g +: 4]);
    end

endmodule

// File: rtl/present_round_engine.sv
// rtl/present_round_engine.sv - iterative PRESENT-80 encryption, one round per clock
`ifndef PRESENT_SIZE
`define PRESENT_SIZE 64
`endif

module present_round_engine #(
    parameter int BLOCK_WIDTH = `PRESENT_SIZE,
    parameter int KEY_WIDTH   = present_pkg::KEY_WIDTH,
    parameter int NUM_ROUNDS  = present_pkg::NUM_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BLOCK_WIDTH-1:0] plaintext,
    input  logic [KEY_WIDTH-1:0]   key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BLOCK_WIDTH-1:0] ciphertext,
    output logic                   busy
);

    present_pkg::state_t r_fsm;
    present_pkg::state_t w_fsm_next;

    logic [BLOCK_WIDTH-1:0] r_state;
    logic [BLOCK_WIDTH-1:0] r_cipher;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [4:0]             r_round_ctr;

    logic [BLOCK_WIDTH-1:0] w_round_key;
    logic [BLOCK_WIDTH-1:0] w_sbox;
    logic [BLOCK_WIDTH-1:0] w_perm;
    logic [KEY_WIDTH-1:0]   w_key_rot;
    logic [KEY_WIDTH-1:0]   w_key_next;
    logic                   w_last_round;

    // The round key is always the top 64 bits of the running key register
    assign w_round_key  = r_key[KEY_WIDTH-1 -: BLOCK_WIDTH];
    assign w_last_round = (r_round_ctr == 5'(NUM_ROUNDS));

    present_sbox_layer #(
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_sbox_layer (
        .i_data (r_state ^ w_round_key),
        .o_data (w_sbox)
    );

    // Bit permutation: bit i moves to (16*i) mod 63, the top bit stays put
    genvar g;
    for (g = 0; g < BLOCK_WIDTH; g++) begin : g_perm
        assign w_perm[(g == BLOCK_WIDTH - 1) ? g : ((g * (BLOCK_WIDTH / 4)) % (BLOCK_WIDTH - 1))] = w_sbox[g];
    end

    assign w_key_rot = {r_key[KEY_WIDTH-62:0], r_key[KEY_WIDTH-1:KEY_WIDTH-61]};

    // Key schedule: rotated key, S-box on the top nibble, round counter folded into bits 19..15
    always_comb begin
        w_key_next                   = w_key_rot;
        w_key_next[KEY_WIDTH-1 -: 4] = present_pkg::sbox(w_key_rot[KEY_WIDTH-1 -: 4]);
        w_key_next[19:15]            = w_key_rot[19:15] ^ r_round_ctr;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= present_pkg::IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (r_fsm)
            present_pkg::IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_fsm_next = present_pkg::RUN;
                end
            end
            present_pkg::RUN: begin
                if (w_last_round) begin
                    w_fsm_next = present_pkg::FINAL;
                end
            end
            present_pkg::FINAL: begin
                w_fsm_next = present_pkg::DONE;
            end
            present_pkg::DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_fsm_next = present_pkg::IDLE;
                end
            end
            default: begin
                w_fsm_next = present_pkg::IDLE;
            end
        endcase
    end

    // Datapath: latch inputs on accept, one round per RUN cycle, whitening in FINAL
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= '0;
            r_key       <= '0;
            r_cipher    <= '0;
            r_round_ctr <= '0;
        end else begin
            case (r_fsm)
                present_pkg::IDLE: begin
                    if (in_valid) begin
                        r_state     <= plaintext;
                        r_key       <= key;
                        r_round_ctr <= 5'd1;
                    end
                end
                present_pkg::RUN: begin
                    r_state <= w_perm;
                    r_key   <= w_key_next;
                    // Hold at the last round so the counter never wraps to zero
                    if (!w_last_round) begin
                        r_round_ctr <= r_round_ctr + 5'd1;
                    end
                end
                present_pkg::FINAL: begin
                    r_cipher <= r_state ^ w_round_key;
                end
                default: begin
                end
            endcase
        end
    end

    assign ciphertext = r_cipher;

endmodule

// File: tb/tb_present_round_engine.sv
// tb/tb_present_round_engine.sv - directed known-answer bench for present_round_engine
`ifndef PRESENT_SIZE
`define PRESENT_SIZE 64
`endif

module tb_present_round_engine;

    localparam int BW = `PRESENT_SIZE;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] tb_pt;
    logic [79:0]   tb_key;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] ciphertext;
    logic          busy;

    int total;
    int bad;

    present_round_engine dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (tb_pt),
        .key        (tb_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkint(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts edges until out_valid is seen (bounded at 60)
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
    endtask

    task automatic run_block(input string tag, input logic [63:0] pt, input logic [79:0] k,
                             input logic [63:0] exp);
        int n;
        tb_pt     = pt;
        tb_key    = k;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(n);
        checkint({tag, "_latency"}, n, 32);
        check64({tag, "_ct"}, ciphertext, exp);
        @(posedge clk);
        #1;
        check1({tag, "_idle_after"}, in_ready, 1'b1);
    endtask

    initial begin
        int n;
        int n2;
        int seen;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tb_pt     = '0;
        tb_key    = '0;

        repeat (2) @(posedge clk);
        #1;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check64("rst_ct", ciphertext, 64'h0);
        rst = 1'b0;

        run_block("kat0", 64'h0, 80'h0, 64'h5579C1387B228445);
        run_block("kat_key1", 64'h0, 80'hFFFFFFFFFFFFFFFFFFFF, 64'hE72C46C0F5945049);
        run_block("kat_pt1", 64'hFFFFFFFFFFFFFFFF, 80'h0, 64'hA112FFC72F68417B);

        // Backpressure: ciphertext must stay put while out_ready is low
        tb_pt     = 64'hFFFFFFFFFFFFFFFF;
        tb_key    = 80'hFFFFFFFFFFFFFFFFFFFF;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check1("bp_busy_run", busy, 1'b1);
        wait_valid(n);
        checkint("bp_latency", n, 33 - 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check1("bp_hold_valid", out_valid, 1'b1);
            check64("bp_hold_ct", ciphertext, 64'h3333DCD3213210D2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check1("bp_release_in_ready", in_ready, 1'b1);
        check1("bp_release_out_valid", out_valid, 1'b0);
        check1("bp_release_busy", busy, 1'b0);

        // in_valid pulse with different data during RUN must be ignored
        tb_pt    = 64'h0;
        tb_key   = 80'h0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check1("ign_in_ready_low", in_ready, 1'b0);
        tb_pt    = 64'hFFFFFFFFFFFFFFFF;
        tb_key   = 80'hFFFFFFFFFFFFFFFFFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tb_pt    = 64'h0123456789ABCDEF;
        tb_key   = 80'h0;
        wait_valid(n);
        checkint("ign_latency", n + 5, 32);
        check64("ign_ct", ciphertext, 64'h5579C1387B228445);
        @(posedge clk);
        #1;

        // Reset in the middle of round 12 aborts without an out_valid pulse
        tb_pt    = 64'hFFFFFFFFFFFFFFFF;
        tb_key   = 80'hFFFFFFFFFFFFFFFFFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check1("abort_in_ready", in_ready, 1'b1);
        check1("abort_out_valid", out_valid, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check64("abort_ct", ciphertext, 64'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkint("abort_no_valid", seen, 0);
        run_block("after_abort", 64'h0, 80'h0, 64'h5579C1387B228445);

        // Back-to-back: one block every 34 cycles with both handshakes held high
        tb_pt     = 64'h0;
        tb_key    = 80'h0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tb_pt = 64'hFFFFFFFFFFFFFFFF;
        wait_valid(n);
        checkint("b2b_first_latency", n, 32);
        check64("b2b_first_ct", ciphertext, 64'h5579C1387B228445);
        wait_valid(n2);
        checkint("b2b_period", n2, 34);
        check64("b2b_second_ct", ciphertext, 64'hA112FFC72F68417B);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check1("b2b_idle", in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
